nonoverlap_1010: RTL and testbench

Serial bit-stream sequence detector that flags each occurrence of the pattern 1-0-1-0 (first bit first) on a 1-bit input, sampled once per clock. Detection is non-overlapping: after a match, the search restarts from scratch and no bits of the matched pattern are reused. Build-time parameter selects Moore (registered-state output) or Mealy (combinational output) flavour. Used as a standalone leaf FSM in digital-logic exercises and benches.

---
 rtl/nonoverlap_1010.sv | 59 +++++
 tb/tb_nonoverlap_1010.sv | 133 +++++++++++++
 2 files changed

// File: rtl/nonoverlap_1010.sv
// Serial 1010 sequence detector, non-overlapping. MEALY selects a registered-state
// (Moore) or state-and-input (Mealy) decoded detection flag.
module nonoverlap_1010 #(
  parameter int unsigned MEALY = 0
) (
  input  logic clk,
  input  logic rstn,  // active-high synchronous reset despite the name
  input  logic in,
  output logic out
);

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1010 = 3'd4
  } state_t;

  state_t state_q, state_d;

  // State register; reset wins over any input on the same edge.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and detection flag; a match always restarts from S0 or S1 so
  // no bits of a completed pattern are reused.
  always_comb begin
    state_d = S0;
    out     = 1'b0;
    unique case (state_q)
      S0:   state_d = in ? S1 : S0;
      S1:   state_d = in ? S1 : S10;
      S10:  state_d = in ? S101 : S0;
      S101: begin
        if (in) begin
          state_d = S1;
        end else if (MEALY != 0) begin
          state_d = S0;
          out     = ~rstn;
        end else begin
          state_d = S1010;
        end
      end
      S1010: begin
        // Only reachable in the Moore flavour.
        state_d = in ? S1 : S0;
        out     = (MEALY == 0) ? ~rstn : 1'b0;
      end
      default: state_d = S0;  // unused encodings recover to idle
    endcase
  end

endmodule

// File: tb/tb_nonoverlap_1010.sv
// Directed-vector and random-stream checks of both detector flavours in parallel.
module tb_nonoverlap_1010;

  logic clk;
  logic rstn;
  logic din;
  logic out_moore;
  logic out_mealy;

  int n_cmp;
  int n_fail;

  typedef struct packed {
    logic rstn;
    logic din;
    logic moore;
    logic mealy;
  } vec_t;

  vec_t vecs[$];

  nonoverlap_1010 #(.MEALY(0)) u_moore (
    .clk  (clk),
    .rstn (rstn),
    .in   (din),
    .out  (out_moore)
  );

  nonoverlap_1010 #(.MEALY(1)) u_mealy (
    .clk  (clk),
    .rstn (rstn),
    .in   (din),
    .out  (out_mealy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic b, input logic mo, input logic me);
    vec_t v;
    v.rstn  = r;
    v.din   = b;
    v.moore = mo;
    v.mealy = me;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0b expected %0b", name, idx, act, exp);
    end
  endtask

  // Drive one bit after the falling edge; outputs are sampled before the next rising edge,
  // so Moore shows state from earlier bits and Mealy also reflects the current bit.
  task automatic step(input logic r, input logic b, output logic mo, output logic me);
    @(negedge clk);
    rstn = r;
    din  = b;
    #1;
    mo = out_moore;
    me = out_mealy;
  endtask

  initial begin
    logic mo, me;
    logic [3:0] hist;
    int cnt;
    logic m, prev_m;
    logic b;

    n_cmp  = 0;
    n_fail = 0;
    rstn   = 1'b1;
    din    = 1'b0;

    // Reset hold with input toggling.
    add(1, 0, 0, 0); add(1, 1, 0, 0); add(1, 0, 0, 0);
    // Single match 1,0,1,0,0.
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 1); add(0, 0, 1, 0);
    // Non-overlap 10101010: matches at bits 4 and 8 only, then a trailing 0.
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 1);
    add(0, 1, 1, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 1);
    add(0, 0, 1, 0);
    // Prefix recovery 11011010, then a trailing 0.
    add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0);
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 1);
    add(0, 0, 1, 0);
    // Prefix recovery 1001010, then a trailing 0.
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0);
    add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 1); add(0, 0, 1, 0);
    // Reset mid-sequence in S101 with in=0: Mealy flag must stay low.
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(1, 0, 0, 0);
    add(0, 0, 0, 0);
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 1);
    // Reset while Moore sits in the match state: flag forced low, then cleared.
    add(1, 0, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rstn, vecs[i].din, mo, me);
      check("moore", i, mo, vecs[i].moore);
      check("mealy", i, me, vecs[i].mealy);
    end

    // Random stream against a history/distance reference: a match needs the last four
    // bits to be 1010 and at least four bits since the last match or reset.
    step(1'b1, 1'b0, mo, me);
    check("rand_rst_moore", 0, mo, 1'b0);
    check("rand_rst_mealy", 0, me, 1'b0);
    hist   = 4'b0000;
    cnt    = 0;
    prev_m = 1'b0;
    for (int i = 0; i < 27; i++) begin
      b = 1'($urandom_range(0, 1));
      if (i < 4) b = i[0] ? 1'b0 : 1'b1;  // guarantee at least one match
      m = (cnt >= 3) && ({hist[2:0], b} == 4'b1010);
      step(1'b0, b, mo, me);
      check("rand_moore", i, mo, prev_m);
      check("rand_mealy", i, me, m);
      hist   = {hist[2:0], b};
      cnt    = m ? 0 : cnt + 1;
      prev_m = m;
    end
    step(1'b0, 1'b0, mo, me);
    check("rand_tail_moore", 27, mo, prev_m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
